// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

    // Padder control states.
    typedef enum logic [2:0] {
        ABSORB = 3'd0,
        PAD80  = 3'd1,
        LEN    = 3'd2,
        EMIT   = 3'd3,
        DONE   = 3'd4
    } pad_state_e;

    localparam int          BLOCK_BITS     = 512;
    localparam int          BLOCK_BYTES    = 64;
    localparam int          LEN_FIELD_BYTE = 56;
    localparam logic [7:0]  PAD_BYTE       = 8'h80;

    // Returns blk with byte position idx (byte 0 = most significant) replaced by val.
    function automatic logic [BLOCK_BITS-1:0] put_byte(
        input logic [BLOCK_BITS-1:0] blk,
        input logic [5:0]            idx,
        input logic [7:0]            val
    );
        logic [BLOCK_BITS-1:0] res;
        res = blk;
        for (int b = 0; b < BLOCK_BYTES; b++) begin
            res[BLOCK_BITS-1-8*b -: 8] = (idx == 6'(b)) ? val : res[BLOCK_BITS-1-8*b -: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/msg_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks and, on
// end-of-message, appends the 0x80 marker, zero fill and the 64-bit length.
module msg_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            data_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    input  logic                  stop_i,
    output logic [BLOCK_BITS-1:0] block_o,
    output logic                  block_valid_o,
    input  logic                  block_ready_i,
    output logic                  last_o,
    output logic                  padded_o
);

    pad_state_e            r_state;
    logic [BLOCK_BITS-1:0] r_buf;
    logic [5:0]            r_idx;
    logic [LEN_W-1:0]      r_bitlen;
    logic                  r_final;
    logic                  r_padding;
    logic                  r_valid;
    logic                  r_last;
    logic                  r_padded;

    // Bytes are only taken while absorbing and before end-of-message is seen.
    assign byte_ready_o  = (r_state == ABSORB) && !stop_i;
    assign block_o       = r_buf;
    assign block_valid_o = r_valid;
    assign last_o        = r_last;
    assign padded_o      = r_padded;

    // Padder FSM: owns the block buffer, byte index, bit length and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ABSORB;
            r_buf     <= '0;
            r_idx     <= 6'd0;
            r_bitlen  <= '0;
            r_final   <= 1'b0;
            r_padding <= 1'b0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_padded  <= 1'b0;
        end else begin
            case (r_state)
                ABSORB: begin
                    if (byte_valid_i && !stop_i) begin
                        r_buf    <= put_byte(r_buf, r_idx, data_i);
                        r_idx    <= r_idx + 6'd1;
                        r_bitlen <= r_bitlen + LEN_W'(8);
                        if (r_idx == 6'd63) begin
                            r_state <= EMIT;
                            r_final <= 1'b0;
                            r_valid <= 1'b1;
                            r_last  <= 1'b0;
                        end else begin
                            r_state <= ABSORB;
                        end
                    end else if (stop_i) begin
                        r_state   <= PAD80;
                        r_padding <= 1'b1;
                    end else begin
                        r_state <= ABSORB;
                    end
                end

                PAD80: begin
                    r_buf <= put_byte(r_buf, r_idx, PAD_BYTE);
                    r_idx <= r_idx + 6'd1;
                    // Marker leaves room for the length field only up to byte 55.
                    if (r_idx <= 6'(LEN_FIELD_BYTE - 1)) begin
                        r_state <= LEN;
                    end else begin
                        r_state <= EMIT;
                        r_final <= 1'b0;
                        r_valid <= 1'b1;
                        r_last  <= 1'b0;
                    end
                end

                LEN: begin
                    r_buf[63:0] <= 64'(r_bitlen);
                    r_final     <= 1'b1;
                    r_state     <= EMIT;
                    r_valid     <= 1'b1;
                    r_last      <= 1'b1;
                end

                EMIT: begin
                    if (block_ready_i) begin
                        r_buf   <= '0;
                        r_idx   <= 6'd0;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        if (r_final) begin
                            r_state   <= DONE;
                            r_padded  <= 1'b1;
                            r_bitlen  <= '0;
                            r_final   <= 1'b0;
                            r_padding <= 1'b0;
                        end else if (r_padding) begin
                            r_state <= LEN;
                        end else begin
                            r_state <= ABSORB;
                        end
                    end else begin
                        r_state <= EMIT;
                    end
                end

                DONE: begin
                    r_bitlen <= '0;
                    if (!stop_i) begin
                        r_state  <= ABSORB;
                        r_padded <= 1'b0;
                    end else begin
                        r_state <= DONE;
                    end
                end

                default: begin
                    r_state <= ABSORB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msg_padder.sv
// Scoreboard testbench for msg_padder: a queue-based reference model pads
// each message from first principles; a monitor checks every accepted block.
module tb_msg_padder;

    logic         clk;
    logic         rst;
    logic [7:0]   data_i;
    logic         byte_valid_i;
    logic         byte_ready_o;
    logic         stop_i;
    logic [511:0] block_o;
    logic         block_valid_o;
    logic         block_ready_i;
    logic         last_o;
    logic         padded_o;

    msg_padder #(.LEN_W(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_i        (data_i),
        .byte_valid_i  (byte_valid_i),
        .byte_ready_o  (byte_ready_o),
        .stop_i        (stop_i),
        .block_o       (block_o),
        .block_valid_o (block_valid_o),
        .block_ready_i (block_ready_i),
        .last_o        (last_o),
        .padded_o      (padded_o)
    );

    typedef struct {
        logic [511:0] blk;
        logic         last;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] msg[$];
    int         checks   = 0;
    int         failures = 0;
    logic       stall    = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Block-sink ready: random acceptance, forced low while stall is set.
    initial begin
        block_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            block_ready_i = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every handshake pops one expected block and compares it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (block_valid_o === 1'b1 && block_ready_i === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_block", 512'(block_valid_o), 512'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("block_data", block_o, e.blk);
                    chk("block_last", 512'(last_o), 512'(e.last));
                end
            end
        end
    end

    // Model: slice a padded byte stream into blocks from block index first_b onward.
    task automatic push_blocks(input logic [7:0] s[$], input int first_b, input bit final_msg);
        exp_t e;
        int   nb;
        nb = s.size() / 64;
        for (int b = first_b; b < nb; b++) begin
            e.blk = '0;
            for (int j = 0; j < 64; j++) e.blk[511-8*j -: 8] = s[b*64+j];
            e.last = final_msg && (b == nb - 1);
            exp_q.push_back(e);
        end
    endtask

    // Model: full padding of the current message, queue the blocks not yet emitted.
    task automatic push_final();
        logic [7:0]  p[$];
        logic [63:0] bits;
        p    = msg;
        bits = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 0; i < 8; i++) p.push_back(bits[63-8*i -: 8]);
        push_blocks(p, msg.size() / 64, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  n;
        bit  ok;
        ok = 1'b0;
        byte_valid_i = 1'b1;
        data_i       = b;
        for (n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (byte_ready_o === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        byte_valid_i = 1'b0;
        if (!ok) begin
            chk("byte_accept_timeout", 512'(ok), 512'd1);
        end else begin
            msg.push_back(b);
            if (msg.size() % 64 == 0) begin
                push_blocks(msg, msg.size() / 64 - 1, 1'b0);
                @(negedge clk);
                chk("full_block_valid_latency", 512'(block_valid_o), 512'd1);
                chk("full_block_last", 512'(last_o), 512'd0);
                @(posedge clk);
                #1;
            end
        end
        if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    // End the message and follow the handshake sequence back to absorbing.
    task automatic finish_msg();
        int  lat;
        bit  seen;
        bit  timed;
        int  tail;
        tail  = msg.size() % 64;
        timed = (tail != 0) || (msg.size() == 0);
        push_final();
        stop_i = 1'b1;
        seen   = 1'b0;
        lat    = 0;
        for (int n = 1; n <= 6 && !seen; n++) begin
            @(negedge clk);
            if (n == 1) chk("ready_low_on_stop", 512'(byte_ready_o), 512'd0);
            if (block_valid_o === 1'b1) begin
                seen = 1'b1;
                lat  = n;
            end
        end
        if (timed) chk("pad_valid_latency", 512'(lat), (tail <= 55) ? 512'd4 : 512'd3);
        seen = 1'b0;
        for (int n = 0; n < 1000 && !seen; n++) begin
            @(negedge clk);
            if (padded_o === 1'b1) seen = 1'b1;
        end
        chk("padded_seen", 512'(seen), 512'd1);
        chk("scoreboard_drained", 512'(exp_q.size()), 512'd0);
        chk("ready_low_in_done", 512'(byte_ready_o), 512'd0);
        @(posedge clk);
        #1;
        stop_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_done", 512'(byte_ready_o), 512'd1);
        chk("padded_cleared", 512'(padded_o), 512'd0);
        msg.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        msg.delete();
        exp_q.delete();
        @(negedge clk);
        chk("rst_block", block_o, 512'd0);
        chk("rst_valid", 512'(block_valid_o), 512'd0);
        chk("rst_last", 512'(last_o), 512'd0);
        chk("rst_padded", 512'(padded_o), 512'd0);
        chk("rst_ready", 512'(byte_ready_o), 512'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_abc();
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h63);
    endtask

    initial begin
        logic [511:0] held;
        logic         held_last;
        int           len;
        rst          = 1'b1;
        stop_i       = 1'b0;
        byte_valid_i = 1'b0;
        data_i       = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // "abc"
        send_abc();
        finish_msg();

        // Empty message
        finish_msg();

        // 55 bytes: fits in one block
        for (int i = 0; i < 55; i++) send_byte(8'($urandom_range(32, 126)));
        finish_msg();

        // 56 bytes: length spills into a second block
        for (int i = 0; i < 56; i++) send_byte(8'($urandom_range(32, 126)));
        finish_msg();

        // 64 bytes with a 5-cycle stall on the full block
        stall = 1'b1;
        for (int i = 0; i < 64; i++) send_byte(8'($urandom_range(32, 126)));
        @(negedge clk);
        held      = block_o;
        held_last = last_o;
        chk("stall_last", 512'(held_last), 512'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 512'(block_valid_o), 512'd1);
            chk("stall_block", block_o, held);
            chk("stall_last_hold", 512'(last_o), 512'(held_last));
        end
        stall = 1'b0;
        @(posedge clk);
        #1;
        finish_msg();

        // Reset after 20 bytes, then "abc" again
        for (int i = 0; i < 20; i++) send_byte(8'($urandom_range(32, 126)));
        do_reset();
        send_abc();
        finish_msg();

        // Random-length messages
        for (int m = 0; m < 6; m++) begin
            len = $urandom_range(0, 150);
            for (int i = 0; i < len; i++) send_byte(8'($urandom_range(32, 126)));
            finish_msg();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
